factorial_sched: RTL

Round-robin scheduler that shares one factorial engine (4-bit operand, 46-bit result, `in_valid`/`out_valid`/`out_busy` interface) among NREQ requesters. It accepts one request at a time and dispatches it to the engine. It answers operands 0 and 1 locally, bounds each engine job with a watchdog, and returns the result to the requester that issued it over a valid/ready response handshake. It sits between the requester fabric and the factorial engine; its `fact_*` ports connect directly to the engine.

---
 rtl/factorial_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/factorial_sched.sv
// ---------------------------------------------------------------------------
// factorial_sched
//
// Shares a single factorial engine among NREQ requesters. One request is
// accepted at a time via a round-robin arbiter, dispatched to the engine
// (operands 0 and 1 are answered locally), guarded by a watchdog, and the
// result is returned to the requester that issued it over a valid/ready
// response handshake.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   req_valid[NREQ]    per-requester request valid
//   req_data[4*NREQ]   operands, requester i on bits [4i+3:4i]
//   req_ready[NREQ]    one-hot grant (combinational, IDLE only)
//   resp_valid[NREQ]   one-hot response valid, held until accepted
//   resp_data[46]      result (1 for operands 0/1, 0 on timeout)
//   resp_err           timeout flag, qualified by resp_valid
//   resp_ready[NREQ]   per-requester response accept
//   fact_in_data[4]    operand to the engine
//   fact_in_valid      one-cycle dispatch strobe to the engine
//   fact_out_data[46]  engine result
//   fact_out_valid     engine result strobe
//   fact_out_busy      engine busy; dispatch is held off while set
// ---------------------------------------------------------------------------
module factorial_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [4*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     resp_valid,
    output logic [45:0]         resp_data,
    output logic                resp_err,
    input  logic [NREQ-1:0]     resp_ready,
    output logic [3:0]          fact_in_data,
    output logic                fact_in_valid,
    input  logic [45:0]         fact_out_data,
    input  logic                fact_out_valid,
    input  logic                fact_out_busy
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [3:0]      op;
    logic [IDW-1:0]  id;
    logic [IDW-1:0]  last;
    logic [7:0]      timer;
    logic [45:0]     result;
    logic            err;

    // Round-robin arbitration
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_found;
    logic [IDW-1:0]  idx;
    logic [3:0]      op_slice [NREQ];
    logic [3:0]      sel_op;
    logic            accept;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign op_slice[gi]   = req_data[4*gi +: 4];
            // Response valid is a decode of the registered state and id,
            // so it drops to zero immediately on reset.
            assign resp_valid[gi] = (state == RESP) && (id == IDW'(gi));
        end
    endgenerate

    // Search starts one past the last granted requester and wraps, so a
    // requester that was just served has the lowest priority next time.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last) + k) % NREQ);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign sel_op = op_slice[grant_id];

    // Grant is combinational but forced low while reset is asserted so no
    // transfer can be signalled to the fabric during reset.
    assign req_ready = ((state == IDLE) && resetn) ? grant : '0;
    assign accept    = |(req_valid & req_ready);

    // Dispatch strobe must react to busy within the same cycle, hence it is
    // a decode rather than a register.
    assign fact_in_valid = (state == ISSUE) && !fact_out_busy;
    assign fact_in_data  = op;
    assign resp_data     = result;
    assign resp_err      = err;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            last   <= IDW'(NREQ - 1);
            op     <= '0;
            id     <= '0;
            timer  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op   <= sel_op;
                        id   <= grant_id;
                        last <= grant_id;
                        if (sel_op <= 4'd1) begin
                            // 0! = 1! = 1, no engine round trip needed
                            result <= 46'd1;
                            err    <= 1'b0;
                            state  <= RESP;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!fact_out_busy) begin
                        timer <= '0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // A result arriving on the last watchdog cycle still wins.
                    if (fact_out_valid) begin
                        result <= fact_out_data;
                        err    <= 1'b0;
                        state  <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        result <= '0;
                        err    <= 1'b1;
                        state  <= RESP;
                    end else begin
                        timer  <= timer + 8'd1;
                    end
                end
                RESP: begin
                    // Only the owning requester can retire the response.
                    if (resp_ready[id]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
